button_debounce_multi: RTL
==========================

# button_debounce_multi

Parametrised multi-channel debouncer for the 5 MHz front-panel clock domain. Each channel synchronises one raw button input, requires the input to be stable for a programmable time before accepting a press or a release, and produces a stable level plus one-cycle press, release, long-press and auto-repeat pulses. It feeds the control FSMs directly; all outputs are registered and synchronous to clk5.

## Interface
- NUM_CH, 4: number of independent button channels (≥1)
- DEBOUNCE_CYCLES, 40000: stable cycles required to accept an edge (8 ms at 5 MHz); ≥2
- LONG_CYCLES, 2500000: held cycles after press before the long pulse (0.5 s); ≥2
- REPEAT_CYCLES, 500000: auto-repeat period after the long pulse (100 ms); ≥2

- clk5  in  1  system clock, 5 MHz
- reset  in  1  reset, synchronous, active-high; clock clk5
- raw  in  NUM_CH  asynchronous button inputs, active-high
- repeat_en  in  1  global auto-repeat enable, sampled every cycle
- level  out  NUM_CH  debounced button state
- press  out  NUM_CH  one-cycle pulse on accepted press
- release  out  NUM_CH  one-cycle pulse on accepted release
- long_press  out  NUM_CH  one-cycle pulse, at most once per hold
- repeat  out  NUM_CH  one-cycle pulse every REPEAT_CYCLES after long_press while repeat_en=1

## Operation
- Per channel: 2-flop synchroniser (raw -> s1 -> s), then a 4-state FSM with a debounce counter (width $clog2(DEBOUNCE_CYCLES)) and a hold counter (width $clog2 of max(LONG_CYCLES, REPEAT_CYCLES)). Channels share nothing except repeat_en.
- IDLE: level=0. s=1 -> CONFIRM_PRESS, debounce counter cleared.
- CONFIRM_PRESS: s=0 -> IDLE (abort, no outputs). s=1: counter increments; when counter = DEBOUNCE_CYCLES-1 and s=1 -> HELD, level<=1, press<=1 for one cycle, hold counter cleared, long-done flag cleared.
- HELD: hold counter increments each cycle. Before long-done: counter = LONG_CYCLES-1 -> long_press one cycle, set long-done, clear hold counter. After long-done with repeat_en=1: counter = REPEAT_CYCLES-1 -> repeat one cycle, clear counter. After long-done with repeat_en=0: counter holds at 0, no pulses. s=0 -> CONFIRM_RELEASE, debounce counter cleared.
- CONFIRM_RELEASE: level stays 1; hold counter paused, no long_press/repeat. s=1 -> HELD (hold counter resumes from paused value). s=0: counter increments; at DEBOUNCE_CYCLES-1 with s=0 -> IDLE, level<=0, release<=1 for one cycle.
- Any press/release bounce restarts the confirmation window from zero via the abort path.
- press and release never both high on a channel in the same cycle; long_press and repeat never both high.

## Timing
- Reset: all FSMs IDLE, counters 0, synchroniser flops 0, level/press/release/long_press/repeat = 0 on the clock after reset is sampled high. Reset mid-hold gives no release pulse.
- Button held through reset deassertion is treated as a new press.
- Latency (edge 0 = edge that first samples raw changed, raw then stable): level change and press/release pulse appear after edge DEBOUNCE_CYCLES+2.
- long_press after edge LONG_CYCLES following the press edge; repeats every REPEAT_CYCLES edges thereafter.
- repeat_en deasserted mid-period: counter freezes at 0 on next edge; reassertion restarts a full period.
- Counters never wrap; all compares are equality on the current count.

## Test plan
Bench parameters: NUM_CH=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8.
- Clean press: raw[0] 0->1 sampled at edge 0, held -> level[0] and press[0] rise after edge 6; press[0] high exactly 1 cycle; ch1 outputs stay 0.
- Bounce: raw[0] high 3 cycles, low 1, then high stable from edge 10 -> exactly one press[0], after edge 16; glitch of ≤3 cycles from IDLE -> no output change.
- Long/repeat: press at edge P with repeat_en=0, held 60 cycles -> long_press at P+20, no repeat. Repeat with repeat_en=1 -> repeat at P+28, P+36, P+44 ...
- Release: held, raw[0] 1->0 sampled at edge R -> release[0] and level[0]=0 after edge R+6. A 2-cycle low glitch while HELD -> no release, level stays 1, long_press timing shifts by the paused cycles.
- Independence/simultaneous: raw[0] and raw[1] pressed at the same edge with a 1-cycle bounce on ch1 -> press[0] at +6, press[1] 1 cycle... per abort rule, ch1 press 6 edges after its last rise.
- Reset mid-operation: reset high for 1 cycle while ch0 HELD and ch1 in CONFIRM_PRESS -> all outputs 0 next cycle, no release pulse; raw held -> press re-issued DEBOUNCE_CYCLES+2 edges after reset drops.

Source files
------------

// File: rtl/button_debounce_multi.sv
// Multi-channel button debouncer: per-channel 2-flop synchroniser, press/release confirmation,
// long-press and auto-repeat pulses. The release/repeat ports carry a _pulse suffix because the bare names are reserved words.
module button_debounce_multi #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 40000,
  parameter int LONG_CYCLES     = 2500000,
  parameter int REPEAT_CYCLES   = 500000
) (
  input  logic              clk5,
  input  logic              reset,
  input  logic [NUM_CH-1:0] raw,
  input  logic              repeat_en,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] press,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] long_press,
  output logic [NUM_CH-1:0] repeat_pulse
);

  typedef enum logic [1:0] {
    IDLE            = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    HELD            = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } state_t;

  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX);

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic              s1_reg;
      logic              s_reg;
      state_t            state_reg, state_next;
      logic [DB_W-1:0]   db_reg, db_next;
      logic [HOLD_W-1:0] hold_reg, hold_next;
      logic              long_done_reg, long_done_next;
      logic              level_reg, level_next;
      logic              press_reg, press_next;
      logic              release_reg, release_next;
      logic              long_reg, long_next;
      logic              repeat_reg, repeat_next;

      always_ff @(posedge clk5) begin
        if (reset) begin
          s1_reg        <= 1'b0;
          s_reg         <= 1'b0;
          state_reg     <= IDLE;
          db_reg        <= '0;
          hold_reg      <= '0;
          long_done_reg <= 1'b0;
          level_reg     <= 1'b0;
          press_reg     <= 1'b0;
          release_reg   <= 1'b0;
          long_reg      <= 1'b0;
          repeat_reg    <= 1'b0;
        end else begin
          s1_reg        <= raw[gi];
          s_reg         <= s1_reg;
          state_reg     <= state_next;
          db_reg        <= db_next;
          hold_reg      <= hold_next;
          long_done_reg <= long_done_next;
          level_reg     <= level_next;
          press_reg     <= press_next;
          release_reg   <= release_next;
          long_reg      <= long_next;
          repeat_reg    <= repeat_next;
        end
      end

      always_comb begin
        state_next     = state_reg;
        db_next        = db_reg;
        hold_next      = hold_reg;
        long_done_next = long_done_reg;
        level_next     = level_reg;
        press_next     = 1'b0;
        release_next   = 1'b0;
        long_next      = 1'b0;
        repeat_next    = 1'b0;
        case (state_reg)
          IDLE: begin
            level_next = 1'b0;
            if (s_reg) begin
              state_next = CONFIRM_PRESS;
              db_next    = '0;
            end
          end
          CONFIRM_PRESS: begin
            if (!s_reg) begin
              state_next = IDLE;
            end else if (db_reg == DB_LAST) begin
              state_next     = HELD;
              level_next     = 1'b1;
              press_next     = 1'b1;
              hold_next      = '0;
              long_done_next = 1'b0;
            end else begin
              db_next = db_reg + DB_W'(1);
            end
          end
          HELD: begin
            // A low sample pauses the hold timer; it resumes if the release is not confirmed.
            if (!s_reg) begin
              state_next = CONFIRM_RELEASE;
              db_next    = '0;
            end else if (!long_done_reg) begin
              if (hold_reg == LONG_LAST) begin
                long_next      = 1'b1;
                long_done_next = 1'b1;
                hold_next      = '0;
              end else begin
                hold_next = hold_reg + HOLD_W'(1);
              end
            end else if (repeat_en) begin
              if (hold_reg == REPEAT_LAST) begin
                repeat_next = 1'b1;
                hold_next   = '0;
              end else begin
                hold_next = hold_reg + HOLD_W'(1);
              end
            end else begin
              hold_next = '0;
            end
          end
          CONFIRM_RELEASE: begin
            if (s_reg) begin
              state_next = HELD;
            end else if (db_reg == DB_LAST) begin
              state_next   = IDLE;
              level_next   = 1'b0;
              release_next = 1'b1;
            end else begin
              db_next = db_reg + DB_W'(1);
            end
          end
          default: begin
            state_next = IDLE;
            level_next = 1'b0;
          end
        endcase
      end

      assign level[gi]         = level_reg;
      assign press[gi]         = press_reg;
      assign release_pulse[gi] = release_reg;
      assign long_press[gi]    = long_reg;
      assign repeat_pulse[gi]  = repeat_reg;
    end
  endgenerate

endmodule
